bloom_filter_ctrl: RTL and testbench

BLOOM_FILTER_CTRL -- requirements
Module: bloom_filter_ctrl

---
 rtl/bloom_filter_ctrl.sv | 118 +++++++++++
 tb/tb_bloom_filter_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_filter_ctrl.sv
// Bloom filter sequencer: turns insert/query requests into filter strobes,
// waits out the filter latency, returns query results and keeps statistics.
module bloom_filter_ctrl #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [7:0]       req_hash1,
    input  logic [7:0]       req_hash2,
    output logic             req_ready,
    input  logic             clr_req,
    output logic             bf_enable,
    output logic             bf_write,
    output logic             bf_check,
    output logic             bf_clear,
    output logic [7:0]       bf_hash1,
    output logic [7:0]       bf_hash2,
    input  logic             bf_word_detected,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [CNT_W-1:0] insert_count,
    output logic [CNT_W-1:0] query_count,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       clr_pend;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            clr_pend     <= 1'b0;
            bf_hash1     <= 8'd0;
            bf_hash2     <= 8'd0;
            rsp_hit      <= 1'b0;
            insert_count <= '0;
            query_count  <= '0;
            hit_count    <= '0;
        end else begin
            if (clr_req) begin
                clr_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        state <= CLEAR;
                    end else if (req_valid) begin
                        bf_hash1 <= req_hash1;
                        bf_hash2 <= req_hash2;
                        state    <= req_op ? CHECK : WRITE;
                    end
                end
                WRITE: begin
                    if (insert_count != CNT_MAX) begin
                        insert_count <= insert_count + CNT_ONE;
                    end
                    state <= IDLE;
                end
                CHECK: begin
                    wait_cnt <= 4'(LATENCY);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        rsp_hit <= bf_word_detected;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (query_count != CNT_MAX) begin
                            query_count <= query_count + CNT_ONE;
                        end
                        if (rsp_hit && hit_count != CNT_MAX) begin
                            hit_count <= hit_count + CNT_ONE;
                        end
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    // a pulse landing on the clear cycle earns one more clear
                    clr_pend     <= clr_req;
                    insert_count <= '0;
                    query_count  <= '0;
                    hit_count    <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ready is gated by reset so it reads 0 while reset is held
    assign req_ready = !reset && (state == IDLE) && !clr_pend;
    assign bf_enable = (state == WRITE) || (state == CHECK) || (state == WAIT);
    assign bf_write  = (state == WRITE);
    assign bf_check  = (state == CHECK);
    assign bf_clear  = (state == CLEAR);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// Bench for bloom_filter_ctrl: scoreboarded query results on a LATENCY=1
// instance, plus a LATENCY=4 instance for latency and mid-query reset.
module tb_bloom_filter_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // instance a: LATENCY=1, CNT_W=4
    logic       rst_a = 1'b1;
    logic       req_valid_a = 1'b0, req_op_a = 1'b0;
    logic [7:0] req_hash1_a = 8'd0, req_hash2_a = 8'd0;
    logic       req_ready_a, clr_req_a = 1'b0;
    logic       bf_enable_a, bf_write_a, bf_check_a, bf_clear_a;
    logic [7:0] bf_hash1_a, bf_hash2_a;
    logic       bf_word_detected_a;
    logic       rsp_valid_a, rsp_ready_a = 1'b0, rsp_hit_a;
    logic [3:0] insert_count_a, query_count_a, hit_count_a;

    // instance b: LATENCY=4, CNT_W=16
    logic        rst_b = 1'b1;
    logic        req_valid_b = 1'b0, req_op_b = 1'b0;
    logic [7:0]  req_hash1_b = 8'd0, req_hash2_b = 8'd0;
    logic        req_ready_b, clr_req_b = 1'b0;
    logic        bf_enable_b, bf_write_b, bf_check_b, bf_clear_b;
    logic [7:0]  bf_hash1_b, bf_hash2_b;
    logic        bf_word_detected_b = 1'b1;
    logic        rsp_valid_b, rsp_ready_b = 1'b0, rsp_hit_b;
    logic [15:0] insert_count_b, query_count_b, hit_count_b;

    bloom_filter_ctrl #(.LATENCY(1), .CNT_W(4)) dut_a (
        .clock(clock), .reset(rst_a),
        .req_valid(req_valid_a), .req_op(req_op_a),
        .req_hash1(req_hash1_a), .req_hash2(req_hash2_a),
        .req_ready(req_ready_a), .clr_req(clr_req_a),
        .bf_enable(bf_enable_a), .bf_write(bf_write_a),
        .bf_check(bf_check_a), .bf_clear(bf_clear_a),
        .bf_hash1(bf_hash1_a), .bf_hash2(bf_hash2_a),
        .bf_word_detected(bf_word_detected_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_hit(rsp_hit_a),
        .insert_count(insert_count_a), .query_count(query_count_a),
        .hit_count(hit_count_a)
    );

    bloom_filter_ctrl #(.LATENCY(4), .CNT_W(16)) dut_b (
        .clock(clock), .reset(rst_b),
        .req_valid(req_valid_b), .req_op(req_op_b),
        .req_hash1(req_hash1_b), .req_hash2(req_hash2_b),
        .req_ready(req_ready_b), .clr_req(clr_req_b),
        .bf_enable(bf_enable_b), .bf_write(bf_write_b),
        .bf_check(bf_check_b), .bf_clear(bf_clear_b),
        .bf_hash1(bf_hash1_b), .bf_hash2(bf_hash2_b),
        .bf_word_detected(bf_word_detected_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_hit(rsp_hit_b),
        .insert_count(insert_count_b), .query_count(query_count_b),
        .hit_count(hit_count_b)
    );

    // filter model for instance a: 256-bit array, membership needs both bits
    logic [255:0] bits = '0;
    always @(posedge clock) begin
        if (bf_clear_a) begin
            bits <= '0;
        end else if (bf_write_a) begin
            bits[bf_hash1_a] <= 1'b1;
            bits[bf_hash2_a] <= 1'b1;
        end
    end
    assign bf_word_detected_a = bits[bf_hash1_a] & bits[bf_hash2_a];

    int clr_cnt = 0;
    always @(negedge clock) begin
        if (bf_clear_a) clr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    bit exp_q[$];

    always @(negedge clock) begin
        if (!rst_a && rsp_valid_a && rsp_ready_a) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got response hit=%0b expected none",
                         rsp_hit_a);
            end else begin
                chk("sb_rsp_hit", 32'(rsp_hit_a), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic op, input logic [7:0] h1,
                         input logic [7:0] h2);
        int k = 0;
        @(posedge clock); #1;
        req_valid_a = 1'b1;
        req_op_a    = op;
        req_hash1_a = h1;
        req_hash2_a = h2;
        @(negedge clock);
        while (!req_ready_a && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("accept", 32'(req_ready_a), 32'd1);
        @(posedge clock); #1;
        req_valid_a = 1'b0;
    endtask

    task automatic handshake();
        @(posedge clock); #1 rsp_ready_a = 1'b1;
        @(posedge clock); #1 rsp_ready_a = 1'b0;
    endtask

    task automatic query(input logic [7:0] h1, input logic [7:0] h2,
                         input bit exp, input int hold,
                         input int qc, input int hc);
        int n = 0;
        exp_q.push_back(exp);
        issue(1'b1, h1, h2);
        do begin
            @(negedge clock);
            n++;
        end while (!rsp_valid_a && n < 40);
        chk("rsp_latency", 32'(n), 32'd3);
        repeat (hold) begin
            @(negedge clock);
            chk("hold_valid", 32'(rsp_valid_a), 32'd1);
            chk("hold_hit", 32'(rsp_hit_a), 32'(exp));
            chk("hold_ready", 32'(req_ready_a), 32'd0);
            chk("hold_qcnt", 32'(query_count_a), 32'(qc));
            chk("hold_hcnt", 32'(hit_count_a), 32'(hc));
        end
        handshake();
        @(negedge clock);
        chk("qcnt", 32'(query_count_a), 32'(qc + 1));
        chk("hcnt", 32'(hit_count_a), 32'(hc + int'(exp)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        int seen;

        // reset state
        #3;
        chk("rst_ready", 32'(req_ready_a), 32'd0);
        chk("rst_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst_strobes", {28'd0, bf_enable_a, bf_write_a,
                            bf_check_a, bf_clear_a}, 32'd0);
        chk("rst_icnt", 32'(insert_count_a), 32'd0);
        repeat (2) @(posedge clock);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(req_ready_a), 32'd1);

        // insert, then hit / miss / stalled hit
        issue(1'b0, 8'h74, 8'h61);
        @(negedge clock);
        chk("write_on", {30'd0, bf_write_a, bf_enable_a}, 32'd3);
        @(negedge clock);
        chk("write_off", 32'(bf_write_a), 32'd0);
        chk("icnt1", 32'(insert_count_a), 32'd1);
        query(8'h74, 8'h61, 1'b1, 0, 0, 0);
        query(8'h20, 8'h73, 1'b0, 0, 1, 1);
        query(8'h74, 8'h61, 1'b1, 5, 2, 1);

        // two clear pulses during the query give a single clear afterwards
        c0 = clr_cnt;
        exp_q.push_back(1'b0);
        issue(1'b1, 8'h20, 8'h73);
        clr_req_a = 1'b1;
        @(posedge clock); #1 clr_req_a = 1'b0;
        clr_req_a = 1'b1;
        @(posedge clock); #1 clr_req_a = 1'b0;
        @(negedge clock);
        chk("clr_resp_valid", 32'(rsp_valid_a), 32'd1);
        chk("clr_resp_bfclr", 32'(bf_clear_a), 32'd0);
        handshake();
        repeat (6) begin
            @(negedge clock);
            if (bf_clear_a) chk("clr_no_enable", 32'(bf_enable_a), 32'd0);
        end
        chk("clr_once", 32'(clr_cnt - c0), 32'd1);
        chk("clr_icnt", 32'(insert_count_a), 32'd0);
        chk("clr_qcnt", 32'(query_count_a), 32'd0);
        chk("clr_hcnt", 32'(hit_count_a), 32'd0);
        chk("clr_ready", 32'(req_ready_a), 32'd1);

        // a pulse on the clear cycle itself earns a second clear
        c0 = clr_cnt;
        @(posedge clock); #1 clr_req_a = 1'b1;
        @(posedge clock); #1 clr_req_a = 1'b0;
        @(posedge clock); #1 clr_req_a = 1'b1;
        @(negedge clock);
        chk("clr_cycle", 32'(bf_clear_a), 32'd1);
        @(posedge clock); #1 clr_req_a = 1'b0;
        repeat (5) @(negedge clock);
        chk("clr_twice", 32'(clr_cnt - c0), 32'd2);

        // request while busy is ignored; hashes hold
        exp_q.push_back(1'b0);
        issue(1'b1, 8'h74, 8'h61);
        repeat (3) @(negedge clock);
        chk("busy_resp", 32'(rsp_valid_a), 32'd1);
        @(posedge clock); #1;
        req_valid_a = 1'b1; req_op_a = 1'b0;
        req_hash1_a = 8'h11; req_hash2_a = 8'h22;
        repeat (2) @(posedge clock);
        #1 req_valid_a = 1'b0;
        handshake();
        @(negedge clock);
        chk("busy_icnt", 32'(insert_count_a), 32'd0);
        chk("busy_qcnt", 32'(query_count_a), 32'd1);
        chk("hold_hash", {16'd0, bf_hash1_a, bf_hash2_a}, 32'h7461);
        chk("idle_strobes", {28'd0, bf_enable_a, bf_write_a,
                             bf_check_a, bf_clear_a}, 32'd0);

        // insert counter saturation
        for (int i = 0; i < 17; i++) begin
            issue(1'b0, 8'(i), 8'(i + 100));
            if (i == 14) begin
                repeat (2) @(negedge clock);
                chk("icnt15", 32'(insert_count_a), 32'd15);
            end
        end
        repeat (2) @(negedge clock);
        chk("icnt_sat", 32'(insert_count_a), 32'd15);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // instance b: latency 4
        @(posedge clock); #1;
        req_valid_b = 1'b1; req_op_b = 1'b1;
        req_hash1_b = 8'h05; req_hash2_b = 8'h06;
        @(negedge clock);
        chk("b_ready", 32'(req_ready_b), 32'd1);
        @(posedge clock); #1 req_valid_b = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rsp_valid_b && n < 40);
        chk("b_latency", 32'(n), 32'd6);
        chk("b_hit", 32'(rsp_hit_b), 32'd1);
        @(posedge clock); #1 rsp_ready_b = 1'b1;
        @(posedge clock); #1 rsp_ready_b = 1'b0;
        @(negedge clock);
        chk("b_qcnt", 32'(query_count_b), 32'd1);
        chk("b_hcnt", 32'(hit_count_b), 32'd1);

        // reset in the middle of WAIT
        @(posedge clock); #1 req_valid_b = 1'b1;
        @(negedge clock);
        @(posedge clock); #1 req_valid_b = 1'b0;
        repeat (3) @(negedge clock);
        chk("b_in_wait", {30'd0, bf_enable_b, bf_check_b}, 32'd2);
        rst_b = 1'b1;
        #1;
        chk("b_rst_ctl", {26'd0, req_ready_b, rsp_valid_b, rsp_hit_b,
                          bf_enable_b, bf_check_b, bf_clear_b}, 32'd0);
        chk("b_rst_hash", {16'd0, bf_hash1_b, bf_hash2_b}, 32'd0);
        chk("b_rst_cnt", {query_count_b, hit_count_b}, 32'd0);
        repeat (2) @(posedge clock);
        #1 rst_b = 1'b0;
        @(negedge clock);
        chk("b_rel_ready", 32'(req_ready_b), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid_b) seen++;
        end
        chk("b_no_rsp", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
